wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter and scoreboard for the 32×32 register file. It shares the file's single write port between two producers, the ALU and the load unit, using a valid/ready handshake, and drives the file's `write_rg`/`write_data` from registers. It also tracks which destination registers have a write in flight, so issue logic can stall on RAW and WAW hazards. It sits between the execute/memory stages and the register file's write port.

## Interface
- No parameters. Register count (32), index width (5) and data width (32) are fixed to match the register file.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `alu_valid`  in  1  ALU has a result to write.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `mem_valid`  in  1  load unit has a result to write.
- `mem_rd`  in  5  load destination register.
- `mem_data`  in  32  load result.
- `mem_ready`  out  1  load request accepted this cycle.
- `issue_valid`  in  1  an instruction writing `issue_rd` is issuing.
- `issue_rd`  in  5  destination register of the issuing instruction.
- `issue_ready`  out  1  issue permitted (no WAW conflict).
- `chk1_rg`  in  5  source register 1 to check.
- `chk2_rg`  in  5  source register 2 to check.
- `chk1_busy`  out  1  `chk1_rg` has a pending write.
- `chk2_busy`  out  1  `chk2_rg` has a pending write.
- `write_rg`  out  5  register file write index, registered; 0 means no write.
- `write_data`  out  32  register file write data, registered.

## Operation
- **Handshake:**
  - A requester transfers on a cycle where its `valid` and `ready` are both 1.
  - `ready` is combinational from both `valid` inputs and the priority state. At most one `ready` is 1 per cycle.
  - A `ready` is never 1 unless the matching `valid` is 1.
  - Requesters hold `rd`/`data` stable while `valid` is 1 and not yet accepted.
- **Arbitration:**
  - Only one requester valid: it is granted.
  - Both valid: the one not granted last time wins.
  - The last-grant flop updates only on a transfer.
- **Write port:** on a transfer, the next edge loads `write_rg` ← granted `rd` and `write_data` ← granted `data`. With no transfer, the next edge loads `write_rg` ← 0 and `write_data` holds its value.
- **rd = 0:** the request is accepted normally. `write_rg` becomes 0, so nothing is written, and no scoreboard bit changes.
- **Scoreboard:** `pend[31:1]` is one flop per register; `pend[0]` is constantly 0.
  - **Set:** `pend[issue_rd]` sets on the edge where `issue_valid & issue_ready` and `issue_rd != 0`.
  - **Clear:** `pend[write_rg]` clears on the edge where `write_rg != 0`, which is the same edge on which the register file captures the data.
  - **Set and clear on the same register, same edge:** set wins.
- **issue_ready:** `issue_ready = (issue_rd == 0) | ~pend[issue_rd]`. Issue to a register already in flight stalls.
- **Busy checks:** `chkN_busy = pend[chkN_rg]`. They reflect the current flop state only, with no same-cycle bypass, and are 0 for register 0.
- **Orphan writes:** a write to a register with no `pend` bit set is still performed. The clear is then a no-op.

## Timing
- **Reset values:**
  - `write_rg` = 0, `write_data` = 0.
  - `pend` = all 0.
  - Last-grant = MEM, so the ALU wins the first tie.
  - Combinational outputs follow from this state.
- **Reset mid-operation:** asserting `rst` drops any in-flight write (`write_rg` forced to 0) and clears all pending bits immediately, asynchronously.
- **Latency:**
  - Transfer at edge N: `write_rg`/`write_data` are valid after edge N.
  - The register file captures the data at edge N+1, and `pend` clears at edge N+1.
  - The register reads the new value after edge N+1.
- **Throughput:** one write per cycle total. With both requesters held valid, grants alternate ALU, MEM, ALU, …
- **Scoreboard-set latency:** an issue at edge N makes `chkN_busy` for that register 1 after edge N.

## Configuration
- Macro `WB_RR_EN`:
  - **Defined:** round-robin arbitration as described above.
  - **Undefined:**
    - Fixed priority: MEM always wins a tie, and ALU is granted only when `mem_valid` = 0.
    - The last-grant flop is not implemented.
    - All other behaviour is identical.

## Test plan
- **Reset:** hold `rst` = 0, then release with all `valid` inputs = 0 → `write_rg` = 0, `write_data` = 0, `issue_ready` = 1, `chk1_busy` = 0 and `chk2_busy` = 0 for any register.
- **Single write:**
  - Stimulus: issue `rd` = 5 at edge 0, then assert `alu_valid`, `rd` = 5, `data` = 0xDEADBEEF at edge 2.
  - `chk1_busy`(5) = 1 after edge 0.
  - `alu_ready` = 1 in the cycle before edge 2.
  - `write_rg` = 5 and `write_data` = 0xDEADBEEF after edge 2.
  - `chk1_busy`(5) = 0 after edge 3.
- **Contention:** ALU (`rd` = 1) and MEM (`rd` = 2) held valid for 4 cycles → with `WB_RR_EN`, grants are ALU, MEM, ALU, MEM; without it, MEM wins every tie.
- **WAW stall:** `pend`[7] = 1 and `issue_rd` = 7 → `issue_ready` = 0.
- **Set/clear on the same edge:** `issue_rd` = 7 is issued on the same edge that `write_rg` = 7 commits → `pend`[7] remains 1.
- **rd = 0 and async reset:**
  - A MEM request with `rd` = 0 is accepted with `write_rg` = 0 afterwards and no `pend` change.
  - Asserting `rst` while `write_rg` = 3 forces `write_rg` = 0 and `pend` = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between ALU and load unit and tracks pending writes
//   clk, rst (async, active-low)
//   alu_valid/alu_rd/alu_data -> alu_ready ; mem_valid/mem_rd/mem_data -> mem_ready
//   issue_valid/issue_rd -> issue_ready (stalls on WAW) ; chk1_rg/chk2_rg -> chk1_busy/chk2_busy
//   write_rg/write_data: registered write port, write_rg = 0 means no write
//   WB_RR_EN defined: round-robin on ties; undefined: MEM always wins a tie
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic [4:0]  chk1_rg,
  input  logic [4:0]  chk2_rg,
  output logic        chk1_busy,
  output logic        chk2_busy,
  output logic [4:0]  write_rg,
  output logic [31:0] write_data
);
  logic [31:1] pend_q, pend_d;
  logic [31:0] pend;
  logic [4:0]  write_rg_q, write_rg_d;
  logic [31:0] write_data_q, write_data_d;
  logic        issue_set;
`ifdef WB_RR_EN
  logic last_mem_q, last_mem_d;
  always_comb begin
    alu_ready  = alu_valid & (~mem_valid | last_mem_q);
    mem_ready  = mem_valid & ~(alu_valid & last_mem_q);
    last_mem_d = alu_ready ? 1'b0 : mem_ready ? 1'b1 : last_mem_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_mem_q <= 1'b1;
    else last_mem_q <= last_mem_d;
`else
  assign alu_ready = alu_valid & ~mem_valid;
  assign mem_ready = mem_valid;
`endif
  assign pend        = {pend_q, 1'b0};
  assign issue_ready = (issue_rd == 5'd0) | ~pend[issue_rd];
  assign issue_set   = issue_valid & issue_ready;
  assign chk1_busy   = pend[chk1_rg];
  assign chk2_busy   = pend[chk2_rg];
  assign write_rg    = write_rg_q;
  assign write_data  = write_data_q;
  always_comb begin
    write_rg_d   = alu_ready ? alu_rd : mem_ready ? mem_rd : 5'd0;
    write_data_d = alu_ready ? alu_data : mem_ready ? mem_data : write_data_q;
    // set is OR'd after the clear so an issue wins over a commit to the same register
    for (int i = 1; i < 32; i++)
      pend_d[i] = (issue_set & (issue_rd == 5'(i))) | (pend_q[i] & (write_rg_q != 5'(i)));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pend_q       <= '0;
      write_rg_q   <= '0;
      write_data_q <= '0;
    end else begin
      pend_q       <= pend_d;
      write_rg_q   <= write_rg_d;
      write_data_q <= write_data_d;
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed check of wb_arbiter against a transaction-level model
module tb_wb_arbiter;
  logic        clk, rst;
  logic        alu_valid, mem_valid, issue_valid;
  logic [4:0]  alu_rd, mem_rd, issue_rd, chk1_rg, chk2_rg;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, issue_ready, chk1_busy, chk2_busy;
  logic [4:0]  write_rg;
  logic [31:0] write_data;
  int n_vec, n_err;
  bit          m_pend [32];
  logic [4:0]  m_rg;
  logic [31:0] m_data;
  bit          m_last_mem, alu_acc, mem_acc;
  logic [4:0]  cont_exp [4];

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .chk1_rg(chk1_rg), .chk2_rg(chk2_rg), .chk1_busy(chk1_busy), .chk2_busy(chk2_busy),
    .write_rg(write_rg), .write_data(write_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_rg = 0; m_data = 0; m_last_mem = 1; alu_acc = 0; mem_acc = 0;
  endtask

  // one clock: check combinational outputs, advance the model, check registered outputs
  task automatic step();
    bit ar, mr, ir;
    #1;
    if (alu_valid && mem_valid) begin
`ifdef WB_RR_EN
      ar = m_last_mem;
`else
      ar = 0;
`endif
      mr = !ar;
    end else begin
      ar = alu_valid; mr = mem_valid;
    end
    ir = (issue_rd == 0) || !m_pend[issue_rd];
    check("alu_ready", alu_ready, ar);
    check("mem_ready", mem_ready, mr);
    check("issue_ready", issue_ready, ir);
    check("chk1_busy", chk1_busy, m_pend[chk1_rg]);
    check("chk2_busy", chk2_busy, m_pend[chk2_rg]);
    if (m_rg != 0) m_pend[m_rg] = 0;
    if (issue_valid && ir && issue_rd != 0) m_pend[issue_rd] = 1;
    if (ar) begin m_rg = alu_rd; m_data = alu_data; m_last_mem = 0; end
    else if (mr) begin m_rg = mem_rd; m_data = mem_data; m_last_mem = 1; end
    else m_rg = 0;
    alu_acc = ar; mem_acc = mr;
    @(posedge clk); #1;
    check("write_rg", write_rg, m_rg);
    check("write_data", write_data, m_data);
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 0; idle();
    alu_rd = 0; mem_rd = 0; issue_rd = 0; alu_data = 0; mem_data = 0;
    chk1_rg = 5; chk2_rg = 31;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    check("rst_write_rg", write_rg, 0);
    check("rst_write_data", write_data, 0);
    check("rst_issue_ready", issue_ready, 1);
    check("rst_busy1", chk1_busy, 0);
    check("rst_busy2", chk2_busy, 0);
    @(negedge clk);
`ifdef WB_RR_EN
    cont_exp = '{5'd1, 5'd2, 5'd1, 5'd2};
`else
    cont_exp = '{5'd2, 5'd2, 5'd2, 5'd2};
`endif
    alu_valid = 1; alu_rd = 1; alu_data = 32'hA1A1A1A1;
    mem_valid = 1; mem_rd = 2; mem_data = 32'hB2B2B2B2;
    for (int i = 0; i < 4; i++) begin
      step();
      check("contention", write_rg, cont_exp[i]);
    end
    idle(); step();
    issue_valid = 1; issue_rd = 5; chk1_rg = 5;
    step();
    issue_valid = 0;
    #1 check("busy5_set", chk1_busy, 1);
    step();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1 check("alu_ready_single", alu_ready, 1);
    step();
    alu_valid = 0;
    check("single_rg", write_rg, 5);
    check("single_data", write_data, 32'hDEADBEEF);
    step();
    #1 check("busy5_clear", chk1_busy, 0);
    chk1_rg = 7;
    issue_valid = 1; issue_rd = 7;
    step();
    #1 check("waw_stall", issue_ready, 0);
    step();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h00000777;
    step();
    alu_valid = 0;
    step();
    #1 check("busy7_clear", chk1_busy, 0);
    alu_valid = 1; alu_rd = 7; alu_data = 32'h00007777;
    step();
    alu_valid = 0; issue_valid = 1; issue_rd = 7;
    check("orphan_rg", write_rg, 7);
    step();
    issue_valid = 0;
    #1 check("setclr_busy7", chk1_busy, 1);
    mem_valid = 1; mem_rd = 0; mem_data = 32'h12345678;
    #1 check("rd0_ready", mem_ready, 1);
    step();
    mem_valid = 0;
    check("rd0_rg", write_rg, 0);
    check("rd0_busy7", chk1_busy, 1);
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33333333;
    step();
    alu_valid = 0;
    check("pre_rst_rg", write_rg, 3);
    #2 rst = 0;
    #1;
    check("async_rg", write_rg, 0);
    check("async_data", write_data, 0);
    check("async_busy7", chk1_busy, 0);
    m_reset();
    @(negedge clk);
    rst = 1;
    for (int c = 0; c < 400; c++) begin
      if (!alu_valid || alu_acc) begin
        alu_valid = $urandom_range(0, 1); alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
      end
      if (!mem_valid || mem_acc) begin
        mem_valid = $urandom_range(0, 1); mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd = 5'($urandom_range(0, 7));
      chk1_rg = 5'($urandom_range(0, 7));
      chk2_rg = 5'($urandom_range(0, 7));
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
